// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bundle of the sprite ROM arbiter: read requests in,
// one-hot grants and tagged pixel responses out.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port.
// Fixed two-cycle latency; out-of-range reads return transparent 0.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 210
) (
    input  logic              CLK,
    input  logic              RST_N,
    sprite_rom_arbiter_if.slave req,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              clr_err,
    output logic              addr_err
);
    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TAG_W-1:0]  ptr_q, ptr_d;
    logic [TAG_W-1:0]  win;
    logic              found;
    logic [TAG_W:0]    sum;
    logic [TAG_W-1:0]  idx;
    logic [ADDR_W-1:0] addr_a [N_REQ];
    logic [ADDR_W-1:0] addr_w;
    logic              oob;
    logic              xfer;
    logic [N_REQ-1:0]  grant;

    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s1_oob_q, s1_oob_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic              s2_oob_q, s2_oob_d;
    logic              addr_err_q, addr_err_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_addr
        assign addr_a[i] = req.req_addr[i*ADDR_W +: ADDR_W];
    end

    // Search ptr, ptr+1, ... wrapping at N_REQ for the first valid.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (sum >= (TAG_W+1)'(N_REQ)) begin
                sum = sum - (TAG_W+1)'(N_REQ);
            end
            idx = sum[TAG_W-1:0];
            if (!found && req.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        grant  = found ? (N_REQ'(1) << win) : '0;
        addr_w = addr_a[win];
        xfer   = found & RST_N;
        oob    = {1'b0, addr_w} >= (ADDR_W+1)'(DEPTH);
    end

    assign req.req_ready = RST_N ? grant : '0;

    always_comb begin
        ptr_d       = ptr_q;
        rom_en_d    = xfer & ~oob;
        rom_addr_d  = rom_addr_q;
        s1_valid_d  = xfer;
        s1_tag_d    = win;
        s1_oob_d    = oob;
        rsp_valid_d = '0;
        s2_oob_d    = s1_oob_q;
        addr_err_d  = addr_err_q;
        if (xfer) begin
            ptr_d = (win == TAG_W'(N_REQ - 1)) ? '0 : win + TAG_W'(1);
        end
        if (xfer && !oob) begin
            rom_addr_d = addr_w;
        end
        if (s1_valid_q) begin
            rsp_valid_d = N_REQ'(1) << s1_tag_q;
        end
        // A new out-of-range accept outranks a simultaneous clear.
        if (xfer && oob) begin
            addr_err_d = 1'b1;
        end else if (clr_err) begin
            addr_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_oob_q    <= 1'b0;
            rsp_valid_q <= '0;
            s2_oob_q    <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_oob_q    <= s1_oob_d;
            rsp_valid_q <= rsp_valid_d;
            s2_oob_q    <= s2_oob_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign rom_en        = rom_en_q;
    assign rom_addr      = rom_addr_q;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_data  = s2_oob_q ? '0 : rom_data;
    assign addr_err      = addr_err_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed scenarios plus
// random round-robin traffic against a queue-based reference model.
module tb_sprite_rom_arbiter;
    localparam int N     = 4;
    localparam int A     = 8;
    localparam int D     = 4;
    localparam int DEPTH = 210;

    typedef struct {
        int          due;
        int          tag;
        logic [D-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         rom_en;
    logic [A-1:0] rom_addr;
    logic [D-1:0] rom_data = '0;
    logic         clr_err = 1'b0;
    logic         addr_err;

    logic [D-1:0] mem [256];
    exp_t         q [$];
    exp_t         e;
    int           checks = 0;
    int           failures = 0;
    int           cyc_n = 0;

    int           m_ptr = 0;
    logic         m_err = 1'b0;
    logic         m_en = 1'b0;
    logic [A-1:0] m_addr = '0;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(A), .DATA_W(D)) bus ();

    sprite_rom_arbiter #(
        .N_REQ(N), .ADDR_W(A), .DATA_W(D), .DEPTH(DEPTH)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .req     (bus),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .clr_err (clr_err),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*A-1:0] pk(input int a0, input int a1,
                                          input int a2, input int a3);
        return {A'(a3), A'(a2), A'(a1), A'(a0)};
    endfunction

    // Monitor: pops the oldest expected response when the DUT presents one.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rsp_valid_in_reset", 32'(bus.rsp_valid), 0);
        end else if (bus.rsp_valid != '0) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected got=%0h exp=none t=%0t",
                         bus.rsp_valid, $time);
            end else begin
                e = q.pop_front();
                check("rsp_cycle", cyc_n, e.due);
                check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.tag);
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            end
        end else if (q.size() != 0 && q[0].due <= cyc_n) begin
            checks++;
            failures++;
            $display("FAIL rsp_missing got=none exp_tag=%0d t=%0t",
                     q[0].tag, $time);
            void'(q.pop_front());
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*A-1:0] a,
                        input logic clr, output int w);
        int           idx;
        logic [A-1:0] ad;
        logic         oob;
        oob = 1'b0;
        @(posedge clk);
        #1;
        check("addr_err", 32'(addr_err), 32'(m_err));
        check("rom_en", 32'(rom_en), 32'(m_en));
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        bus.req_valid = v;
        bus.req_addr  = a;
        clr_err       = clr;
        #2;
        w = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && v[idx]) w = idx;
        end
        check("req_ready", 32'(bus.req_ready), (w < 0) ? 0 : (32'(1) << w));
        if (w >= 0) begin
            ad  = a[w*A +: A];
            oob = (int'(ad) >= DEPTH);
            q.push_back('{due: cyc_n + 2, tag: w, data: oob ? '0 : mem[ad]});
            m_ptr = (w + 1) % N;
            m_en  = !oob;
            if (!oob) m_addr = ad;
        end else begin
            m_en = 1'b0;
        end
        if (w >= 0 && oob) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic idle(input int n);
        int w;
        repeat (n) step('0, '0, 1'b0, w);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '1;
        clr_err       = 1'b0;
        #1;
        check("ready_in_reset", 32'(bus.req_ready), 0);
        q.delete();
        m_ptr  = 0;
        m_err  = 1'b0;
        m_en   = 1'b0;
        m_addr = '0;
        @(posedge clk);
        #1;
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_addr_err", 32'(addr_err), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        bus.req_valid = '0;
        rst_n         = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [N-1:0]   pv;
        logic [N*A-1:0] pa;
        for (int i = 0; i < 256; i++) mem[i] = D'($urandom);
        mem[5] = 4'hA;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        #2;
        do_reset();

        step(4'b0100, pk(0, 0, 5, 0), 1'b0, w);
        idle(3);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, pk($urandom_range(0, 209), $urandom_range(0, 209),
                             $urandom_range(0, 209), $urandom_range(0, 209)),
                 1'b0, w);
        end
        idle(2);

        step(4'b0010, pk(0, 210, 0, 0), 1'b0, w);
        idle(2);
        step('0, '0, 1'b1, w);
        idle(1);
        step(4'b0010, pk(0, 250, 0, 0), 1'b1, w);
        idle(2);
        step('0, '0, 1'b1, w);
        idle(1);

        step(4'b1000, pk(0, 0, 0, 7), 1'b0, w);
        idle(5);
        step(4'b0101, pk(3, 0, 4, 0), 1'b0, w);
        step(4'b0100, pk(0, 0, 4, 0), 1'b0, w);
        idle(2);

        step(4'b0001, pk(0, 0, 0, 0), 1'b0, w);
        step(4'b0001, pk(209, 0, 0, 0), 1'b0, w);
        step(4'b0001, pk(210, 0, 0, 0), 1'b0, w);
        step(4'b0001, pk(1, 0, 0, 0), 1'b0, w);
        idle(3);
        step('0, '0, 1'b1, w);

        step(4'b0011, pk(10, 20, 0, 0), 1'b0, w);
        step(4'b0011, pk(10, 20, 0, 0), 1'b0, w);
        do_reset();
        step(4'b1111, pk(30, 40, 50, 60), 1'b0, w);
        idle(3);

        // Ungranted requesters keep their request and address stable.
        pv = '0;
        pa = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i]        = 1'b1;
                    pa[i*A +: A] = A'($urandom_range(0, 255));
                end
            end
            step(pv, pa, ($urandom_range(0, 9) == 0), w);
            if (w >= 0) pv[w] = 1'b0;
        end
        idle(4);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM read port (4-bit palette pixels, row-major, width*height words) among up to N_REQ pixel requesters, e.g. the weapon, player and enemy renderers.
- Round-robin arbitration; at most one accepted request per cycle; fully pipelined; fixed two-cycle response latency.
- Addresses outside the sprite image return transparent pixel 0 and never reach the ROM.

Parameters:
N_REQ, 4, number of requesters (>=1)
ADDR_W, 8, ROM address width
DATA_W, 4, pixel width
DEPTH, 210, valid words in ROM (30x7 sprite); addresses >= DEPTH are out of range

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester read request
req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_ready  output  N_REQ  one-hot grant, combinational; transfer = req_valid[i] & req_ready[i]
rom_en  output  1  registered ROM read enable
rom_addr  output  ADDR_W  registered ROM address
rom_data  input  DATA_W  ROM data, valid the cycle after rom_en high
rsp_valid  output  N_REQ  registered one-hot response strobe
rsp_data  output  DATA_W  response pixel, valid when any rsp_valid bit high
clr_err  input  1  clears addr_err
addr_err  output  1  sticky out-of-range flag

Behaviour:
- Reset (asynchronous, any time): ptr=0, rom_en=0, rom_addr=0, rsp_valid=0, addr_err=0, pipeline tags and oob flags cleared. In-flight requests are dropped with no response. req_ready stays 0 while RST_N is low.
- Arbitration (cycle t, combinational):
  - Winner w = first i with req_valid[i], searching ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
  - req_ready = one-hot(w), or 0 if no requests. Grant does not depend on the response path (no backpressure).
- Pointer update:
  - On a transfer, ptr <= (w+1) mod N_REQ.
  - With no request, ptr holds.
  - With N_REQ=1, ptr stays 0 and ready = req_valid.
- Stage S1 (edge ending cycle t):
  - oob = (addr_w >= DEPTH).
  - rom_en <= transfer & ~oob.
  - rom_addr <= addr_w on in-range transfers; otherwise holds its previous value.
  - s1_valid <= transfer, s1_tag <= w, s1_oob <= oob.
- Stage S2 (edge ending cycle t+1):
  - rsp_valid <= s1_valid ? one-hot(s1_tag) : 0.
  - s2_oob <= s1_oob.
- Output (cycle t+2):
  - rsp_data = s2_oob ? 0 : rom_data. The ROM presents data for the address enabled in cycle t+1.
  - When rsp_valid = 0, rsp_data is don't-care.
- Latency: request accepted in cycle t yields its response in cycle t+2. Throughput is one per cycle.
- Ordering: responses return in acceptance order; back-to-back transfers from the same requester are allowed.
- addr_err: set on any accepted out-of-range request (edge ending cycle t). clr_err clears it. If set and clear occur on the same edge, set wins.
- Address arithmetic: unsigned compare against DEPTH. No wrap or modulo; ADDR_W must be wide enough to hold DEPTH-1.
- A requester holding req_valid while not granted must keep req_addr stable. The arbiter does not check this.

Test Plan:
- Single request: only req 2 valid, addr 5, ROM[5]=0xA. Expect req_ready=0100 in cycle 0; rom_en=1, rom_addr=5 in cycle 1; rsp_valid=0100, rsp_data=0xA in cycle 2.
- Fairness: all 4 valid continuously for 8 cycles, ptr=0 after reset. Expect grant order 0,1,2,3,0,1,2,3 and responses in the same order, each 2 cycles after its grant.
- Out of range: req 1, addr 210. Expect rom_en=0; rsp_valid=0010 with rsp_data=0 two cycles later; addr_err=1 from the next cycle. Pulsing clr_err clears it. clr_err in the same cycle as a new oob accept leaves addr_err=1.
- Pointer hold and idle: grant to req 3, then 5 idle cycles, then req 0 and req 2 valid together. Expect req 0 granted first (ptr=0 after req 3), then req 2.
- Boundary: addr 209 returns ROM[209] with addr_err unchanged. Back-to-back addrs 0, 209, 210, 1 from req 0 give rsp_data ROM[0], ROM[209], 0, ROM[1] on consecutive cycles.
- Reset mid-operation: accept two requests, assert RST_N low for 1 cycle before their responses. Expect no rsp_valid, rom_en=0, addr_err=0, and ptr=0 on release.
